// File: rtl/mw_add_pkg.sv
// Shared types and helpers for the multi-word add sequencer.
package mw_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of an index/counter able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mw_add_seq.sv
// Multi-word add sequencer: feeds 16-bit slices LSW first to an external registered
// adder and reassembles the wide sum. Optional signed-overflow flag: MW_ADD_SEQ_OVF_EN.
module mw_add_seq
  import mw_add_pkg::*;
#(
  parameter  int NWORDS  = 4,
  parameter  int ADD_LAT = 2,
  localparam int W       = SLICE_W * NWORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [W-1:0]       op_a_i,
  input  logic [W-1:0]       op_b_i,
  input  logic               cin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [W-1:0]       sum_o,
  output logic               cout_o,
`ifdef MW_ADD_SEQ_OVF_EN
  output logic               ovf_o,
`endif
  output logic [SLICE_W-1:0] add_a_o,
  output logic [SLICE_W-1:0] add_b_o,
  output logic               add_ci_o,
  input  logic [SLICE_W-1:0] add_s_i,
  input  logic               add_co_i
);

  localparam int                IDXW     = idx_width(NWORDS);
  localparam int                CNTW     = idx_width(ADD_LAT);
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NWORDS - 1);
  localparam logic [CNTW-1:0]   CNT_INIT = CNTW'(ADD_LAT - 1);

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  // Operands are kept pre-shifted so the next slice always sits in the low bits.
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic [W-1:0]         sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic [SLICE_W-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
  // add_ci_q doubles as the inter-slice carry register.
  logic                 add_ci_q, add_ci_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef MW_ADD_SEQ_OVF_EN
  logic                 ovf_q, ovf_d;
  logic                 a_msb_q, a_msb_d, b_msb_q, b_msb_d;
`endif

  // Next-state and datapath logic for the issue/wait/capture sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    add_ci_d = add_ci_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MW_ADD_SEQ_OVF_EN
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          add_a_d  = op_a_i[SLICE_W-1:0];
          add_b_d  = op_b_i[SLICE_W-1:0];
          add_ci_d = cin_i;
          a_d      = op_a_i >> SLICE_W;
          b_d      = op_b_i >> SLICE_W;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = ISSUE;
`ifdef MW_ADD_SEQ_OVF_EN
          a_msb_d  = op_a_i[W-1];
          b_msb_d  = op_b_i[W-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          for (int k = 0; k < NWORDS; k++) begin
            if (idx_q == IDXW'(k)) begin
              sum_d[k*SLICE_W +: SLICE_W] = add_s_i;
            end else begin
              sum_d[k*SLICE_W +: SLICE_W] = sum_q[k*SLICE_W +: SLICE_W];
            end
          end
          add_ci_d = add_co_i;
          if (idx_q == LAST_IDX) begin
            cout_d  = add_co_i;
            done_d  = 1'b1;
            state_d = DONE;
`ifdef MW_ADD_SEQ_OVF_EN
            ovf_d   = (a_msb_q == b_msb_q) && (add_s_i[SLICE_W-1] != a_msb_q);
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            add_a_d = a_q[SLICE_W-1:0];
            add_b_d = b_q[SLICE_W-1:0];
            a_d     = a_q >> SLICE_W;
            b_d     = b_q >> SLICE_W;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      add_ci_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MW_ADD_SEQ_OVF_EN
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      add_ci_q <= add_ci_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MW_ADD_SEQ_OVF_EN
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
`endif
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign sum_o    = sum_q;
  assign cout_o   = cout_q;
  assign add_a_o  = add_a_q;
  assign add_b_o  = add_b_q;
  assign add_ci_o = add_ci_q;
`ifdef MW_ADD_SEQ_OVF_EN
  assign ovf_o    = ovf_q;
`endif

endmodule

// File: tb/tb_mw_add_seq.sv
// Bench for mw_add_seq: sequencer plus a behavioural ADD_LAT-deep 16-bit adder,
// random and directed wide adds checked by a queue-based scoreboard.
module tb_mw_add_seq;

  localparam int NWORDS  = 4;
  localparam int ADD_LAT = 2;
  localparam int W       = 16 * NWORDS;
  localparam int SLOT    = ADD_LAT + 1;
  localparam int LAT     = NWORDS * SLOT + 1;
  localparam int THR     = NWORDS * SLOT + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  op_a, op_b;
  logic          cin;
  logic          busy_o, done_o, cout_o;
  logic [W-1:0]  sum_o;
  logic [15:0]   add_a_o, add_b_o, add_s;
  logic          add_ci_o, add_co;
`ifdef MW_ADD_SEQ_OVF_EN
  logic          ovf_o;
`endif

  mw_add_seq #(.NWORDS(NWORDS), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_a_i(op_a), .op_b_i(op_b), .cin_i(cin),
    .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .cout_o(cout_o),
`ifdef MW_ADD_SEQ_OVF_EN
    .ovf_o(ovf_o),
`endif
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_ci_o(add_ci_o),
    .add_s_i(add_s), .add_co_i(add_co)
  );

  always #5 clk = ~clk;

  // Registered adder next to the sequencer: result appears ADD_LAT edges after drive.
  logic [16:0] pipe [ADD_LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a_o} + {1'b0, add_b_o} + {16'd0, add_ci_o};
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_s  = pipe[ADD_LAT-1][15:0];
  assign add_co = pipe[ADD_LAT-1][16];

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           c0;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0, n_miss = 0, cyc = 0;
  logic [W-1:0] cur_a, cur_b, last_sum;
  logic         cur_cin, last_cout, cur_valid = 1'b0, have_last = 1'b0, prev_done = 1'b0;
  int           cur_c0, last_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int k = 0; k < NWORDS; k++) v[16*k +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [15:0] slice_of(input logic [W-1:0] v, input int k);
    return 16'(v >> (16 * k));
  endfunction

  // Carry into slice k is the carry out of the low 16*k bits of the plain sum.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    logic [W:0] m, s;
    m = ((W+1)'(1'b1) << (16 * k)) - (W+1)'(1'b1);
    s = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(c);
    return s[16*k];
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input bit hold);
    int   n;
    exp_t e;
    logic [W:0] full;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      chk("accept_timeout", {{W{1'b0}}, busy_o}, {(W+1){1'b0}});
      return;
    end
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    full   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.c0   = cyc;
    exp_q.push_back(e);
    cur_a = a; cur_b = b; cur_cin = c; cur_c0 = cyc; cur_valid = 1'b1;
    if (!hold) start = 1'b0;
  endtask

  // Monitor: slice drive checks while an op is in flight, result checks on done.
  always @(negedge clk) begin
    int   off, k;
    exp_t e;
    if (rst_n) begin
      off = cyc - cur_c0;
      if (cur_valid && off >= 0 && off < NWORDS * SLOT) begin
        k = off / SLOT;
        chk("add_a", {{(W-15){1'b0}}, add_a_o}, {{(W-15){1'b0}}, slice_of(cur_a, k)});
        chk("add_b", {{(W-15){1'b0}}, add_b_o}, {{(W-15){1'b0}}, slice_of(cur_b, k)});
        chk("add_ci", {{W{1'b0}}, add_ci_o}, {{W{1'b0}}, carry_into(cur_a, cur_b, cur_cin, k)});
      end
      if (done_o) begin
        chk("done_width", {{W{1'b0}}, prev_done}, {(W+1){1'b0}});
        if (exp_q.size() == 0) begin
          chk("spurious_done", {{W{1'b0}}, done_o}, {(W+1){1'b0}});
        end else begin
          e = exp_q.pop_front();
          chk("sum", {1'b0, sum_o}, {1'b0, e.sum});
          chk("cout", {{W{1'b0}}, cout_o}, {{W{1'b0}}, e.cout});
`ifdef MW_ADD_SEQ_OVF_EN
          chk("ovf", {{W{1'b0}}, ovf_o}, {{W{1'b0}}, e.ovf});
`endif
          // Cycle 1 follows the accepting edge, so done shows LAT-1 edges later.
          chk("latency", (W+1)'(cyc - e.c0), (W+1)'(LAT - 1));
          if (last_done >= 0) chk("spacing", {{W{1'b0}}, (cyc - last_done) >= THR},
                                  {{W{1'b0}}, 1'b1});
          last_done = cyc;
          last_sum  = e.sum;
          last_cout = e.cout;
          have_last = 1'b1;
        end
      end else if (!busy_o && have_last) begin
        chk("sum_held", {1'b0, sum_o}, {1'b0, last_sum});
        chk("cout_held", {{W{1'b0}}, cout_o}, {{W{1'b0}}, last_cout});
      end
      prev_done = done_o;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, {{W{1'b0}}, busy_o}, {(W+1){1'b0}});
    chk({tag, "_done"}, {{W{1'b0}}, done_o}, {(W+1){1'b0}});
    chk({tag, "_sum"}, {1'b0, sum_o}, {(W+1){1'b0}});
    chk({tag, "_cout"}, {{W{1'b0}}, cout_o}, {(W+1){1'b0}});
    chk({tag, "_add_a"}, {{(W-15){1'b0}}, add_a_o}, {(W+1){1'b0}});
    chk({tag, "_add_b"}, {{(W-15){1'b0}}, add_b_o}, {(W+1){1'b0}});
    chk({tag, "_add_ci"}, {{W{1'b0}}, add_ci_o}, {(W+1){1'b0}});
`ifdef MW_ADD_SEQ_OVF_EN
    chk({tag, "_ovf"}, {{W{1'b0}}, ovf_o}, {(W+1){1'b0}});
`endif
  endtask

  initial begin
    logic [W-1:0] r;
    int           n;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send(W'(64'h0000_0000_0000_0005), W'(64'h3), 1'b0, 1'b0);
    send(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(64'h1), 1'b0, 1'b0);
    send(W'(64'h0001_0000_FFFF_FFFE), W'(64'h0), 1'b1, 1'b0);

    // start held high with changing operands while busy; only the IDLE accept counts.
    send(rand_w(), rand_w(), 1'b0, 1'b1);
    repeat (NWORDS * SLOT) begin
      @(negedge clk);
      op_a = rand_w(); op_b = rand_w(); cin = 1'($urandom);
    end
    send(rand_w(), rand_w(), 1'b1, 1'b0);

    // Reset during the WAIT of slice 2: everything returns to zero, no done follows.
    send(rand_w(), rand_w(), 1'b1, 1'b0);
    repeat (2 * SLOT + 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    cur_valid = 1'b0;
    have_last = 1'b0;
    last_done = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check_zero("postreset");
    send(W'(64'h1234_5678_9ABC_DEF0), W'(64'h0FED_CBA9_8765_4321), 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r = rand_w();
      if (i % 6 == 0) send(r, ~r, 1'b1, 1'b0);
      else send(r, rand_w(), 1'($urandom), 1'b0);
    end

    send(W'(64'h7FFF_FFFF_FFFF_FFFF), W'(64'h1), 1'b0, 1'b0);
    send(W'(64'h1), W'(64'h1), 1'b0, 1'b0);
    send(W'(64'h8000_0000_0000_0000), W'(64'h8000_0000_0000_0000), 1'b0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (W+1)'(exp_q.size()), (W+1)'(0));
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
